fifo_rd_packer: RTL

Read-side consumer for the team's async FIFO, running in the read clock domain. It drains bytes through the FIFO read port (rd_en / data_out / fifo_empty) and packs PACK consecutive bytes into one wide word. Each word is presented downstream on a valid/ready interface. A flush input forces out a partial word with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the async FIFO: packs PACK entries per word.
// Ports: rdclk/rd_rst, FIFO read port (fifo_rd_en, fifo_rd_data,
//   fifo_empty), flush request, valid/ready word output (out_data,
//   out_keep, out_valid, out_ready), word_cnt accept counter, busy flag.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       rdclk,
    input  logic                       rd_rst,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    input  logic                       fifo_empty,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]            out_keep,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_WIDTH-1:0]       word_cnt,
    output logic                       busy
);

    localparam int LW = $clog2(PACK + 1);
    localparam int WW = DATA_WIDTH * PACK;
    localparam logic [LW-1:0] FULL = LW'(PACK);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   cnt_eff;
    logic [LW-1:0]   held;
    logic            inflight;
    logic            slot_free;
    logic            xfer;
    logic [WW-1:0]   acc;
    logic [WW-1:0]   acc_eff;
    logic [WW-1:0]   word;
    logic [PACK-1:0] keep;

    // Accumulator view with this cycle's landing byte already merged, so a
    // transfer in the landing cycle carries that byte.
    always_comb begin
        cnt_eff = cnt + LW'(inflight);
        acc_eff = acc;
        keep    = '0;
        word    = '0;
        for (int i = 0; i < PACK; i++) begin
            if (inflight && cnt == LW'(i)) begin
                acc_eff[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
            end
        end
        for (int i = 0; i < PACK; i++) begin
            keep[i] = LW'(i) < cnt_eff;
            if (keep[i]) begin
                word[i*DATA_WIDTH +: DATA_WIDTH] = acc_eff[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        unique case (state)
            RUN: begin
                xfer = (cnt_eff == FULL) && slot_free;
                if (flush && (cnt != '0 || inflight)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Reads are stopped here, so cnt_eff is the final lane count.
                if (cnt_eff == '0) begin
                    state_nxt = RUN;
                end else if (slot_free) begin
                    xfer      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Lanes committed after this cycle; a read is issued only if its byte
    // is guaranteed a free lane when it lands next cycle.
    assign held       = xfer ? '0 : cnt_eff;
    assign fifo_rd_en = !rd_rst && !fifo_empty && state == RUN && held < FULL;
    assign busy       = state == FLUSH;

    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state     <= RUN;
            cnt       <= '0;
            inflight  <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= held;
            inflight <= fifo_rd_en;
            acc      <= xfer ? '0 : acc_eff;
            if (out_valid && out_ready) begin
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
            if (xfer) begin
                out_data  <= word;
                out_keep  <= keep;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
